// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: width math and accumulator clamping.
package adder_tree_pkg;

  localparam int CLAMP_W = 64;

  typedef struct packed {
    logic               sat;
    logic [CLAMP_W-1:0] val;
  } clamp_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int tree_bits(input int in_bits, input int n);
    return in_bits + clog2(n);
  endfunction

  // value arrives already sign/zero-extended to CLAMP_W; bits must stay below CLAMP_W-1
  function automatic clamp_t sat_clamp(input logic signed [CLAMP_W-1:0] value,
                                       input int bits, input bit sgn);
    logic signed [CLAMP_W-1:0] hi, lo;
    clamp_t r;
    if (sgn) begin
      hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (bits - 1));
    end else begin
      hi = (64'sd1 <<< bits) - 64'sd1;
      lo = 64'sd0;
    end
    r.sat = 1'b0;
    r.val = value;
    if (value > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (value < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered pairwise-add level; each sum grows by one bit so nothing overflows.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int N_PAIRS = 1,
  parameter int W       = 13,
  parameter bit SIGNED  = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_en,
  input  logic [2*N_PAIRS-1:0][W-1:0]   i_data,
  output logic [N_PAIRS-1:0][W:0]       o_data
);

  logic [N_PAIRS-1:0][W:0] r_sum;

  // Loading only on valid beats keeps the last sum parked through bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum <= '0;
    end else if (i_en) begin
      for (int p = 0; p < N_PAIRS; p++)
        r_sum[p] <= {SIGNED & i_data[2*p][W-1], i_data[2*p]} +
                    {SIGNED & i_data[2*p+1][W-1], i_data[2*p+1]};
    end
  end

  assign o_data = r_sum;

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined N-input adder tree with optional saturating per-frame accumulation.
module adder_tree_acc
  import adder_tree_pkg::*;
#(
  parameter int  N_IN      = 8,
  parameter int  IN_BITS   = 13,
  parameter bit  SIGNED    = 1'b1,
  parameter bit  ACC_EN    = 1'b1,
  parameter int  ACC_BITS  = IN_BITS + clog2(N_IN) + 4,
  parameter bit  SAT_EN    = 1'b1,
  localparam int LEVELS    = clog2(N_IN),
  localparam int TREE_BITS = tree_bits(IN_BITS, N_IN),
  localparam int OUT_BITS  = ACC_EN ? ACC_BITS : TREE_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [N_IN*IN_BITS-1:0] in_data,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic                    out_valid,
  output logic [OUT_BITS-1:0]     out_data,
  output logic                    out_sat
);

  logic [LEVELS-1:0]    r_vld;
  logic [TREE_BITS-1:0] w_tree;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= in_valid;
      for (int i = 1; i < LEVELS; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int NP = N_IN >> l;
    localparam int WI = IN_BITS + l - 1;
    logic [2*NP-1:0][WI-1:0] w_in;
    logic [NP-1:0][WI:0]     w_out;
    logic                    w_en;
    if (l == 1) begin : g_src
      assign w_in = in_data;
      assign w_en = in_valid;
    end else begin : g_src
      assign w_in = g_lvl[l-1].w_out;
      assign w_en = r_vld[l-2];
    end
    adder_tree_level #(.N_PAIRS(NP), .W(WI), .SIGNED(SIGNED)) u_lvl (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_en),
      .i_data (w_in),
      .o_data (w_out)
    );
  end

  assign w_tree = g_lvl[LEVELS].w_out;

  if (ACC_EN) begin : g_acc
    logic [LEVELS-1:0]           r_first, r_last;
    logic [ACC_BITS-1:0]         r_acc, r_out;
    logic                        r_sticky, r_out_vld, r_out_sat;
    logic [ACC_BITS-1:0]         w_base, w_next;
    logic [ACC_BITS:0]           w_raw;
    logic signed [CLAMP_W-1:0]   w_raw64;
    logic                        w_sat, w_sticky;
    clamp_t                      w_clamp;

    // One spare bit on the add means the true sum is always visible to the clamp.
    always_comb begin
      w_base  = r_first[LEVELS-1] ? '0 : r_acc;
      w_raw   = {SIGNED & w_base[ACC_BITS-1], w_base} +
                {{(ACC_BITS+1-TREE_BITS){SIGNED & w_tree[TREE_BITS-1]}}, w_tree};
      w_raw64 = {{(CLAMP_W-1-ACC_BITS){SIGNED & w_raw[ACC_BITS]}}, w_raw};
      w_clamp = sat_clamp(w_raw64, ACC_BITS, SIGNED);
      if (SAT_EN) begin
        w_next = w_clamp.val[ACC_BITS-1:0];
        w_sat  = w_clamp.sat;
      end else begin
        w_next = w_raw[ACC_BITS-1:0];
        w_sat  = 1'b0;
      end
      w_sticky = (~r_first[LEVELS-1] & r_sticky) | w_sat;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_first   <= '0;
        r_last    <= '0;
        r_acc     <= '0;
        r_sticky  <= 1'b0;
        r_out     <= '0;
        r_out_vld <= 1'b0;
        r_out_sat <= 1'b0;
      end else begin
        r_first[0] <= in_first;
        r_last[0]  <= in_last;
        for (int i = 1; i < LEVELS; i++) begin
          r_first[i] <= r_first[i-1];
          r_last[i]  <= r_last[i-1];
        end
        r_out_vld <= 1'b0;
        if (r_vld[LEVELS-1]) begin
          if (r_last[LEVELS-1]) begin
            r_out_vld <= 1'b1;
            r_out     <= w_next;
            r_out_sat <= w_sticky;
            r_acc     <= '0;
            r_sticky  <= 1'b0;
          end else begin
            r_acc    <= w_next;
            r_sticky <= w_sticky;
          end
        end
      end
    end

    assign out_valid = r_out_vld;
    assign out_data  = r_out;
    assign out_sat   = r_out_sat;
  end else begin : g_tree
    assign out_valid = r_vld[LEVELS-1];
    assign out_data  = w_tree;
    assign out_sat   = 1'b0;
  end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Bench: plain-tree and accumulating instances share stimulus; frame-level model predicts both.
module tb_adder_tree_acc;
  localparam int N  = 8;
  localparam int IB = 13;
  localparam int TW = 16;
  localparam int AB = 17;
  localparam longint AMAX = (64'sd1 <<< (AB - 1)) - 1;
  localparam longint AMIN = -(64'sd1 <<< (AB - 1));

  logic clk = 1'b0, reset = 1'b0;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [N*IB-1:0] in_data = '0;
  logic t_vld, t_sat, a_vld, a_sat;
  logic [TW-1:0] t_data;
  logic [AB-1:0] a_data;

  always #5 clk = ~clk;

  adder_tree_acc #(.N_IN(N), .IN_BITS(IB), .SIGNED(1'b1), .ACC_EN(1'b0), .ACC_BITS(AB), .SAT_EN(1'b1)) u_tree (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_first(in_first),
    .in_last(in_last), .out_valid(t_vld), .out_data(t_data), .out_sat(t_sat));

  adder_tree_acc #(.N_IN(N), .IN_BITS(IB), .SIGNED(1'b1), .ACC_EN(1'b1), .ACC_BITS(AB), .SAT_EN(1'b1)) u_acc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_first(in_first),
    .in_last(in_last), .out_valid(a_vld), .out_data(a_data), .out_sat(a_sat));

  typedef struct { int cyc; longint data; bit sat; } exp_t;
  exp_t   q_t[$], q_a[$];
  int     cyc = 0, n_tests = 0, n_fail = 0;
  longint h_t = 0, h_a = 0, m_acc = 0;
  bit     h_sat = 0, m_stk = 0;
  int     lanes[N];

  task automatic chk(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, act, exp);
    end
  endtask

  task automatic check_outs();
    longint d;
    bit     due;
    exp_t   e;
    due = 0;
    if (q_t.size() > 0) due = (q_t[0].cyc == cyc);
    chk("t_vld", longint'(t_vld), longint'(due));
    if (due) begin e = q_t.pop_front(); h_t = e.data; end
    d = $signed(t_data);
    chk("t_data", d, h_t);
    chk("t_sat", longint'(t_sat), 0);
    due = 0;
    if (q_a.size() > 0) due = (q_a[0].cyc == cyc);
    chk("a_vld", longint'(a_vld), longint'(due));
    if (due) begin e = q_a.pop_front(); h_a = e.data; h_sat = e.sat; end
    d = $signed(a_data);
    chk("a_data", d, h_a);
    chk("a_sat", longint'(a_sat), longint'(h_sat));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic fill(input int v);
    for (int k = 0; k < N; k++) lanes[k] = v;
  endtask

  // Reference: the tree sum appears 3 cycles on; a frame total appears 4 cycles after its last beat.
  task automatic beat(input bit v, input bit f, input bit l);
    longint s, acc;
    bit     stk;
    s = 0;
    in_valid = v; in_first = f; in_last = l;
    for (int k = 0; k < N; k++) begin
      in_data[k*IB +: IB] = IB'(lanes[k]);
      s += lanes[k];
    end
    if (v) begin
      q_t.push_back('{cyc + 3, s, 1'b0});
      acc = f ? 0 : m_acc;
      stk = f ? 1'b0 : m_stk;
      acc += s;
      if (acc > AMAX) begin acc = AMAX; stk = 1'b1; end
      else if (acc < AMIN) begin acc = AMIN; stk = 1'b1; end
      if (l) begin
        q_a.push_back('{cyc + 4, acc, stk});
        m_acc = 0; m_stk = 1'b0;
      end else begin
        m_acc = acc; m_stk = stk;
      end
    end
    tick();
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_t_vld", longint'(t_vld), 0);
    chk("rst_t_data", longint'(t_data), 0);
    chk("rst_a_vld", longint'(a_vld), 0);
    chk("rst_a_data", longint'(a_data), 0);
    chk("rst_a_sat", longint'(a_sat), 0);
    q_t.delete(); q_a.delete();
    h_t = 0; h_a = 0; h_sat = 0; m_acc = 0; m_stk = 0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    fill(0);
    @(negedge clk);
    do_reset();
    idle(2);

    for (int k = 0; k < N; k++) lanes[k] = k + 1;
    beat(1, 1, 1); idle(5);

    fill(-4096); beat(1, 1, 1);
    fill(4095);  beat(1, 1, 1); idle(5);

    fill(1); beat(1, 1, 0); beat(1, 0, 0); beat(1, 0, 1); idle(6);

    fill(1); beat(1, 1, 0); beat(1, 0, 0); beat(1, 0, 1);
    fill(2); beat(1, 1, 1); idle(6);

    fill(4095); beat(1, 1, 0); beat(1, 0, 0); beat(1, 0, 1);
    fill(1);    beat(1, 1, 1); idle(6);

    fill(-4096); beat(1, 1, 0); beat(1, 0, 0); beat(1, 0, 1); idle(6);

    fill(5); beat(1, 1, 0); beat(1, 0, 0);
    fill(1); beat(1, 1, 1); idle(6);

    fill(3); beat(1, 1, 0); beat(0, 0, 0); beat(1, 0, 1); idle(6);

    fill(3); beat(1, 1, 0); beat(1, 0, 0);
    do_reset();
    fill(1); beat(1, 1, 1); idle(6);

    for (int it = 0; it < 400; it++) begin
      int mode;
      mode = int'($urandom_range(0, 5));
      if (mode == 0) fill(4095);
      else if (mode == 1) fill(-4096);
      else for (int k = 0; k < N; k++) lanes[k] = int'($urandom_range(0, 8191)) - 4096;
      beat($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    idle(8);
    chk("drain_t", longint'(q_t.size()), 0);
    chk("drain_a", longint'(q_a.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
